// File: rtl/line_follow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_follower_pkg
// Description : Shared servo command codes, steering FSM state encoding,
//               sensor bit positions and the sensor-to-state mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package line_follower_pkg;

    // Servo command codes seen by the servo drive
    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_FWD   = 2'b11;

    // Sensor bit positions within the 2-bit sensor vector
    localparam int SENS_L = 1;
    localparam int SENS_R = 0;

    // Steering FSM state encoding (also exported on the LED debug port)
    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_FORWARD = 3'd1,
        ST_LEFT    = 3'd2,
        ST_RIGHT   = 3'd3,
        ST_SEARCH  = 3'd4
    } state_t;

    // Line-following target state for a debounced sensor pair; 00 has no
    // direct target and maps to STOP (callers handle the search path)
    function automatic state_t follow_state(input logic [1:0] d);
        if (d[SENS_L] && d[SENS_R]) begin
            return ST_FORWARD;
        end else if (d[SENS_L]) begin
            return ST_LEFT;
        end else if (d[SENS_R]) begin
            return ST_RIGHT;
        end else begin
            return ST_STOP;
        end
    endfunction

    // Fixed command for the line-following states
    function automatic logic [1:0] state_cmd(input state_t s);
        case (s)
            ST_FORWARD: return CMD_FWD;
            ST_LEFT:    return CMD_LEFT;
            ST_RIGHT:   return CMD_RIGHT;
            default:    return CMD_STOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_follow_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser plus tick-driven debounce for the
//               2-bit line sensor vector.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce
    import line_follower_pkg::*;
#(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] raw,
    output logic [1:0] stable
);

    localparam int             c_cnt_w    = $clog2(DEBOUNCE_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_LEN - 1);

    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_stable;
    logic [c_cnt_w-1:0] r_cnt [2];

    // Bring the asynchronous sensor pins into the clk domain
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit run-length filter: a bit flips only after DEBOUNCE_LEN
    // consecutive disagreeing samples; any agreeing sample restarts the run
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stable <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= '0;
            end
        end else if (tick) begin
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_stable[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == c_cnt_last) begin
                    r_stable[b] <= r_sync2[b];
                    r_cnt[b]    <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + c_cnt_w'(1);
                end
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/line_follow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_follow_ctrl
// Description : Line-follower steering sequencer: sample-rate divider,
//               sensor conditioning and steering FSM with timed line search.
// Revision    : 1.0 - initial release
// ============================================================================
module line_follow_ctrl
    import line_follower_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_LEN   = 4,
    parameter int SEARCH_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sensor,
    output logic [1:0] servo_instruction,
    output logic       lost,
    output logic [2:0] state_dbg
);

    localparam int                  c_div_w       = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0]  c_div_last    = c_div_w'(CLK_DIV - 1);
    localparam int                  c_srch_w      = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [c_srch_w-1:0] c_search_last = c_srch_w'(SEARCH_TIMEOUT - 1);

    logic [c_div_w-1:0]  r_div;
    logic                w_tick;
    logic [1:0]          w_stable;
    state_t              w_follow;
    state_t              r_state;
    logic [1:0]          r_servo;
    logic [1:0]          r_last_dir;
    logic                r_lost;
    logic [c_srch_w-1:0] r_search_cnt;

    assign w_tick = (r_div == c_div_last);

    // Free-running sample divider producing a one-cycle tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    sensor_debounce #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick_unused_guard(w_tick)),
        .raw    (sensor),
        .stable (w_stable)
    );

    assign w_follow = follow_state(w_stable);

    // Steering FSM; state and all outputs are registered on the same edge.
    // Any non-zero sensor pair wins over the search timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_STOP;
            r_servo      <= CMD_STOP;
            r_lost       <= 1'b0;
            r_search_cnt <= '0;
            r_last_dir   <= CMD_LEFT;
        end else if (!en) begin
            r_state      <= ST_STOP;
            r_servo      <= CMD_STOP;
            r_lost       <= 1'b0;
            r_search_cnt <= '0;
        end else if (w_stable != 2'b00) begin
            r_state      <= w_follow;
            r_servo      <= state_cmd(w_follow);
            r_lost       <= 1'b0;
            r_search_cnt <= '0;
            // Only a true turn updates the search direction; FORWARD keeps
            // the direction of the most recent turn
            if (w_follow == ST_LEFT) begin
                r_last_dir <= CMD_LEFT;
            end else if (w_follow == ST_RIGHT) begin
                r_last_dir <= CMD_RIGHT;
            end
        end else begin
            case (r_state)
                ST_FORWARD, ST_LEFT, ST_RIGHT: begin
                    r_state      <= ST_SEARCH;
                    r_servo      <= r_last_dir;
                    r_search_cnt <= '0;
                end
                ST_SEARCH: begin
                    if (w_tick) begin
                        if (r_search_cnt == c_search_last) begin
                            r_state      <= ST_STOP;
                            r_servo      <= CMD_STOP;
                            r_lost       <= 1'b1;
                            r_search_cnt <= '0;
                        end else begin
                            r_search_cnt <= r_search_cnt + c_srch_w'(1);
                        end
                    end
                end
                ST_STOP: begin
                end
                default: begin
                    r_state <= ST_STOP;
                    r_servo <= CMD_STOP;
                end
            endcase
        end
    end

    // Pass-through kept as a function so the tick fan-out stays a plain wire
    function automatic logic tick_unused_guard(input logic t);
        return t;
    endfunction

    assign servo_instruction = r_servo;
    assign lost              = r_lost;
    assign state_dbg         = r_state;

endmodule
`default_nettype wire

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
Steering sequencer for the line-follower. It samples the two line sensors at a fixed rate, synchronises and debounces them, and runs a steering state machine. The FSM drives the 2-bit servo_instruction consumed by the servo drive, and recovers from line loss with a timed search. Sits between the sensor pins and the servo output stage at top level.

Parameters:
CLK_DIV, 100000, clk cycles per sensor sample tick (1 kHz at 100 MHz); must be >= 2.
DEBOUNCE_LEN, 4, consecutive identical samples required before a debounced sensor bit changes; must be >= 1.
SEARCH_TIMEOUT, 500, sample ticks spent searching before stopping; must be >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
en  input  1  run enable; low forces STOP.
sensor  input  2  raw asynchronous sensors; [1] = left, [0] = right; 1 = over line.
servo_instruction  output  2  registered command: 00 stop, 01 left, 10 right, 11 forward.
lost  output  1  registered; high while stopped because the search timed out.
state_dbg  output  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = STOP, servo_instruction = 00, lost = 0, state_dbg = STOP.
  - Debounced bits = 00, debounce counters = 0, divider = 0, search counter = 0, last_dir = LEFT, synchroniser flops = 0.
  - Reset mid-operation overrides everything, including an in-progress search or debounce.
- Synchroniser: 2-flop synchroniser per sensor bit before any other use.
- Tick: divider counts 0..CLK_DIV-1 and wraps. tick is high for exactly one cycle, when divider == CLK_DIV-1.
- Debounce (per bit, on tick only):
  - If the synchronised bit equals the debounced bit, clear its counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_LEN, update the debounced bit and clear the counter in the same edge.
  - A glitch shorter than DEBOUNCE_LEN ticks never propagates.
- FSM: states STOP, FORWARD, LEFT, RIGHT, SEARCH. It is evaluated every clk cycle on the debounced value d. servo_instruction, lost and state_dbg update on the same edge as the state, with no extra latency.
  - Any state with en == 0: go to STOP, lost = 0.
  - STOP (en == 1): d = 11 -> FORWARD; 10 -> LEFT; 01 -> RIGHT; 00 -> stay (lost unchanged).
  - FORWARD/LEFT/RIGHT: follow d using the same map as STOP.
    - d = 00 -> SEARCH, search counter = 0.
    - Entering LEFT sets last_dir = LEFT; entering RIGHT sets last_dir = RIGHT.
  - SEARCH: output = last_dir command. If last_dir is FORWARD-origin, the previously stored last_dir is used.
    - Search counter increments on each tick.
    - Any d != 00 -> the mapped state; counter is cleared.
    - Counter reaches SEARCH_TIMEOUT on a tick with d == 00 -> STOP, lost = 1.
    - If d != 00 and timeout occur in the same cycle, d != 00 wins.
  - lost clears on leaving STOP (line reacquired) or when en goes low.
- Command outputs per state: STOP 00, FORWARD 11, LEFT 01, RIGHT 10, SEARCH = last_dir command.
- End-to-end latency from a stable sensor change: 2 clk (synchroniser) + up to DEBOUNCE_LEN ticks + 1 clk (FSM).
- Counter widths are derived with $clog2 of the respective parameter. No counter may overflow or wrap except the divider.

Decomposition:
- Package line_follower_pkg:
  - Servo command constants: CMD_STOP, CMD_LEFT, CMD_RIGHT, CMD_FWD.
  - FSM state encoding constants.
  - Sensor bit index constants: SENS_L = 1, SENS_R = 0.
- Sub-module sensor_debounce: synchroniser plus debounce for a 2-bit vector.
  - Parameter: DEBOUNCE_LEN.
  - Ports: clk, rst, tick, raw[1:0] -> stable[1:0].
  - Instantiated once. The divider and FSM stay in line_follow_ctrl.

Test Plan:
Bench parameters: CLK_DIV = 4, DEBOUNCE_LEN = 3, SEARCH_TIMEOUT = 5.
1. Reset/enable: hold rst = 0 for 3 cycles with sensor = 11 and en = 1, then release -> outputs stay 00/0/STOP during reset. After release, servo_instruction becomes 11 once the debounce completes: 3 ticks, 12 clk plus synchroniser.
2. Debounce: in FORWARD, pulse sensor = 10 for 2 ticks, then return to 11 -> servo_instruction stays 11. Hold 10 for 3 ticks -> 01 one clk after the debounced update.
3. Search recovery: from RIGHT, drive sensor = 00 -> SEARCH, servo_instruction = 10. Drive 11 after 2 ticks of search -> FORWARD, 11, lost = 0.
4. Timeout: from LEFT, hold 00 -> SEARCH with 01 for 5 ticks, then STOP with 00 and lost = 1. Then drive 01 -> RIGHT, 10, lost = 0.
5. Enable drop mid-search: en = 0 during SEARCH -> STOP, 00 and lost = 0 on the next edge. Reassert en with sensor = 11 -> FORWARD.
6. Reset mid-search: rst = 0 while in SEARCH with last_dir = RIGHT -> STOP/00. After release, a 00 -> 01 -> 00 sequence makes SEARCH drive 10. Verify that last_dir reset to LEFT first, using a FORWARD -> 00 path, which must drive 01.
